// File: rtl/doorlock_pkg.sv
// Shared types and constants for the doorlock keypad front end.
//   scan_state_t  : keypad scanner FSM states
//   KEY_STAR      : key code of the '*' key (row 3, column 0)
//   KEY_HASH      : key code of the '#' key (row 3, column 2)
//   COL_RESET     : column drive pattern after reset (column 0 active-low)
//   rotate_cols   : advance the active-low one-hot column drive by one
//   lowest_row    : index of the lowest-numbered row pulled low
//   col_index     : index of the column currently driven low
package doorlock_pkg;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        HOLD,
        RELEASE
    } scan_state_t;

    localparam logic [3:0] KEY_STAR  = 4'hC;
    localparam logic [3:0] KEY_HASH  = 4'hE;
    localparam logic [3:0] COL_RESET = 4'b1110;

    // 1110 -> 1101 -> 1011 -> 0111 -> 1110
    function automatic logic [3:0] rotate_cols(input logic [3:0] cols);
        return {cols[2:0], cols[3]};
    endfunction

    // Lowest index wins when several rows are low at once.
    function automatic logic [1:0] lowest_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-rate divider: a free-running counter over 0..SCAN_DIV-1 that emits a
// one-cycle tick on the cycle it wraps.
//   clock : system clock
//   reset : synchronous, active-high; clears the counter
//   tick  : one-cycle pulse every SCAN_DIV cycles
module keypad_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce. Drives one column low at a time,
// watches the synchronized rows, and emits a single-cycle strobe with the
// key code once a press has been stable for DEBOUNCE_CNT scan ticks.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
//   clock     : system clock
//   reset     : synchronous, active-high
//   rows_n    : keypad rows, active-low, asynchronous to clock
//   cols_n    : column drive, active-low one-hot
//   key_code  : {row_idx, col_idx} of the last accepted key
//   key_valid : one-cycle strobe, key_code valid in the same cycle
//   key_busy  : high from press detection until the release is debounced
module keypad_scan
    import doorlock_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_CNT   = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE_CNT);

    logic tick;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // Two-flop synchronizer; idle (pulled-up) level is all ones.
    logic [3:0] rs_meta_reg;
    logic [3:0] rs_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rs_meta_reg <= 4'hF;
            rs_reg      <= 4'hF;
        end else begin
            rs_meta_reg <= rows_n;
            rs_reg      <= rs_meta_reg;
        end
    end

    scan_state_t     state_reg,   state_next;
    logic [3:0]      cols_reg,    cols_next;
    logic [1:0]      row_idx_reg, row_idx_next;
    logic [1:0]      col_idx_reg, col_idx_next;
    logic [DB_W-1:0] db_cnt_reg,  db_cnt_next;
    logic [3:0]      code_reg,    code_next;

    logic            row_active;
    logic [1:0]      row_sel;
    logic            same_row;
    logic [DB_W-1:0] db_inc;

    assign row_active = (rs_reg != 4'hF);
    assign row_sel    = lowest_row(rs_reg);
    assign same_row   = row_active && (row_sel == row_idx_reg);
    assign db_inc     = db_cnt_reg + DB_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= SCAN;
            cols_reg    <= COL_RESET;
            row_idx_reg <= 2'd0;
            col_idx_reg <= 2'd0;
            db_cnt_reg  <= '0;
            code_reg    <= 4'h0;
        end else begin
            state_reg   <= state_next;
            cols_reg    <= cols_next;
            row_idx_reg <= row_idx_next;
            col_idx_reg <= col_idx_next;
            db_cnt_reg  <= db_cnt_next;
            code_reg    <= code_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cols_next    = cols_reg;
        row_idx_next = row_idx_reg;
        col_idx_next = col_idx_reg;
        db_cnt_next  = db_cnt_reg;
        code_next    = code_reg;

        unique case (state_reg)
            SCAN: begin
                if (tick) begin
                    if (!row_active) begin
                        cols_next = rotate_cols(cols_reg);
                    end else begin
                        // Column stays put so the key remains visible.
                        row_idx_next = row_sel;
                        col_idx_next = col_index(cols_reg);
                        db_cnt_next  = '0;
                        state_next   = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (same_row) begin
                        db_cnt_next = db_inc;
                        if (db_inc == DB_DONE) begin
                            // Code is loaded here so it is already stable in
                            // the PRESSED cycle, alongside the strobe.
                            code_next  = {row_idx_reg, col_idx_reg};
                            state_next = PRESSED;
                        end
                    end else begin
                        cols_next  = rotate_cols(cols_reg);
                        state_next = SCAN;
                    end
                end
            end
            PRESSED: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (tick && !row_active) begin
                    db_cnt_next = '0;
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (tick) begin
                    if (!row_active) begin
                        db_cnt_next = db_inc;
                        if (db_inc == DB_DONE) begin
                            cols_next  = rotate_cols(cols_reg);
                            state_next = SCAN;
                        end
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            default: begin
                state_next = SCAN;
            end
        endcase
    end

    logic repeat_pulse;

`ifdef KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CNT + 1);
    localparam logic [RPT_W-1:0] RPT_DONE = RPT_W'(REPEAT_CNT);

    logic [RPT_W-1:0] rpt_cnt_reg;
    logic             rpt_pulse_reg;

    // Counts ticks with the accepted key still down; anything outside HOLD
    // restarts the interval.
    always_ff @(posedge clock) begin
        if (reset || (state_reg != HOLD)) begin
            rpt_cnt_reg   <= '0;
            rpt_pulse_reg <= 1'b0;
        end else begin
            rpt_pulse_reg <= 1'b0;
            if (tick && same_row) begin
                if (rpt_cnt_reg + RPT_W'(1) == RPT_DONE) begin
                    rpt_cnt_reg   <= '0;
                    rpt_pulse_reg <= 1'b1;
                end else begin
                    rpt_cnt_reg <= rpt_cnt_reg + RPT_W'(1);
                end
            end
        end
    end

    assign repeat_pulse = rpt_pulse_reg;
`else
    logic repeat_cnt_unused;
    assign repeat_cnt_unused = (REPEAT_CNT > 0);
    assign repeat_pulse      = 1'b0;
`endif

    assign cols_n    = cols_reg;
    assign key_code  = code_reg;
    assign key_valid = (state_reg == PRESSED) || repeat_pulse;
    assign key_busy  = (state_reg != SCAN);

endmodule
